// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared types and constants for the memory port controller.
//   state_e  : response FSM states (IDLE, RESP_IF, RESP_D)
//   owner_e  : which requester owns the memory port this cycle
//   STARVE_MAX_DEFAULT : default limit on data grants while a fetch waits
//   misaligned() : true when a byte address is not word aligned
package mem_port_pkg;

    localparam int unsigned STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    function automatic logic misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_port_arb.sv
// mem_port_arb: combinational arbiter for the shared memory port.
//   if_req, d_req : qualified requests (already masked by reset)
//   starve_hit    : fetch has waited the maximum number of data grants
//   owner         : winner of this cycle (OWN_NONE / OWN_IF / OWN_D)
// Data normally wins; a starved fetch takes the port once.
module mem_port_arb
    import mem_port_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   starve_hit,
    output owner_e owner
);

    // Priority selection with starvation override
    always_comb begin
        owner = OWN_NONE;
        if (if_req && (starve_hit || !d_req)) begin
            owner = OWN_IF;
        end else if (d_req) begin
            owner = OWN_D;
        end else begin
            owner = OWN_NONE;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: shares one single-port synchronous RAM (1-cycle read
// latency) between an instruction-fetch port and a data port.
//   clk, reset            : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request; if_gnt/if_rvalid/if_err/if_rdata
//   d_req/d_we/d_be/...   : data request; d_gnt/d_rvalid/d_rdata
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : RAM port
//   stall                 : some pending request was not granted this cycle
// Grants and RAM controls are combinational in the request cycle; the
// FSM remembers which port owns the read data returning next cycle.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    localparam int unsigned CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic             if_req_s;
    logic             d_req_s;
    logic             starve_hit_s;
    owner_e           owner_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             unused_s;

    // Data accesses are word based; the byte offset is carried by d_be
    assign unused_s = ^d_addr[1:0];

    // Requests are ignored while reset is high
    assign if_req_s     = if_req & ~reset;
    assign d_req_s      = d_req & ~reset;
    assign starve_hit_s = (starve_cnt_q == STARVE_LIM);

    mem_port_arb u_arb (
        .if_req     (if_req_s),
        .d_req      (d_req_s),
        .starve_hit (starve_hit_s),
        .owner      (owner_s)
    );

    // Grants, RAM controls and next FSM state from this cycle's winner
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_err    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = 30'd0;
        mem_wdata = 32'd0;
        state_d   = IDLE;
        case (owner_s)
            OWN_IF: begin
                if_gnt = 1'b1;
                // A misaligned fetch is answered with an error, not a RAM read
                if (misaligned(if_addr[1:0])) begin
                    if_err = 1'b1;
                end else begin
                    mem_en   = 1'b1;
                    mem_addr = if_addr[31:2];
                    state_d  = RESP_IF;
                end
            end
            OWN_D: begin
                d_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = d_addr[31:2];
                if (d_we) begin
                    mem_we    = d_be;
                    mem_wdata = d_wdata;
                end else begin
                    state_d = RESP_D;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        stall = (if_req_s & ~if_gnt) | (d_req_s & ~d_gnt);
    end

    // Starvation counter: counts data grants that overtook a waiting fetch
    always_comb begin
        if (!if_req_s || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && !starve_hit_s) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Read responses; reset suppresses a response that was in flight
    always_comb begin
        if_rvalid = (state_q == RESP_IF) && !reset;
        d_rvalid  = (state_q == RESP_D) && !reset;
        if (reset) begin
            if_rdata_d = 32'd0;
            d_rdata_d  = 32'd0;
        end else begin
            if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
            d_rdata_d  = d_rvalid ? mem_rdata : d_rdata_q;
        end
        if_rdata = if_rdata_d;
        d_rdata  = d_rdata_d;
    end

    // FSM, starvation counter and held read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed bench for mem_port_ctrl with a behavioural
// single-port RAM and a scoreboard of expected read responses.
module tb_mem_port_ctrl;
    import mem_port_pkg::*;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          due;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        stall;

    logic [31:0] ram [0:63];
    logic [31:0] exp_mem [0:63];
    resp_t       sb [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          di;
    int          sc;
    logic        ireq;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] seed(input int i);
        if (i == 4) return 32'h0050_0093;
        return 32'hC0DE_0000 | 32'(i * 17);
    endfunction

    // Behavioural RAM: byte-write, read-first, 1-cycle read latency
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= seed(i);
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr[5:0]];
        end
    end

    mem_port_ctrl #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_err    (if_err),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_if, input logic [31:0] data);
        sb.push_back('{is_if: is_if, data: data, due: cyc + 1});
    endtask

    // Compare this cycle's response outputs against the scoreboard head
    task automatic check_resp();
        resp_t r;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            if (r.is_if) begin
                chk("if_rvalid", 32'(if_rvalid), 32'd1);
                chk("d_rvalid quiet", 32'(d_rvalid), 32'd0);
                chk("if_rdata", if_rdata, r.data);
            end else begin
                chk("d_rvalid", 32'(d_rvalid), 32'd1);
                chk("if_rvalid quiet", 32'(if_rvalid), 32'd0);
                chk("d_rdata", d_rdata, r.data);
            end
        end else begin
            chk("if_rvalid idle", 32'(if_rvalid), 32'd0);
            chk("d_rvalid idle", 32'(d_rvalid), 32'd0);
        end
    endtask

    task automatic drive(input logic ireq_i, input logic [31:0] iaddr,
                         input logic dreq, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] daddr, input logic [31:0] dwdata);
        @(negedge clk);
        if_req  = ireq_i;
        if_addr = iaddr;
        d_req   = dreq;
        d_we    = dwe;
        d_be    = dbe;
        d_addr  = daddr;
        d_wdata = dwdata;
        #1;
        check_resp();
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    task automatic chk_gnt(input string tag, input logic e_if, input logic e_d,
                           input logic e_stall, input logic e_en, input logic [29:0] e_addr);
        chk({tag, " if_gnt"}, 32'(if_gnt), 32'(e_if));
        chk({tag, " d_gnt"}, 32'(d_gnt), 32'(e_d));
        chk({tag, " stall"}, 32'(stall), 32'(e_stall));
        chk({tag, " mem_en"}, 32'(mem_en), 32'(e_en));
        if (e_en) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(e_addr));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) exp_mem[i] = seed(i);
        reset = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_be = 4'h0; d_addr = 32'd0; d_wdata = 32'd0;

        // Requests during reset get nothing
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'd0);
        chk_gnt("in reset", 1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
        chk("in reset mem_we", 32'(mem_we), 32'd0);
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'd0);
        chk_gnt("in reset 2", 1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
        @(negedge clk);
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        #1;
        chk("reset state", 32'(dut.state_q), 32'(IDLE));
        chk("reset starve", 32'(dut.starve_cnt_q), 32'd0);
        chk("reset if_rdata", if_rdata, 32'd0);
        chk("reset d_rdata", d_rdata, 32'd0);
        chk("reset if_err", 32'(if_err), 32'd0);

        // Single fetch of word 4
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        chk_gnt("fetch", 1'b1, 1'b0, 1'b0, 1'b1, 30'd4);
        chk("fetch mem_we", 32'(mem_we), 32'd0);
        push(1'b1, exp_mem[4]);
        idle();

        // Simultaneous fetch and data read: data first
        drive(1'b1, 32'h14, 1'b1, 1'b0, 4'hF, 32'h20, 32'd0);
        chk_gnt("contend", 1'b0, 1'b1, 1'b1, 1'b1, 30'd8);
        push(1'b0, exp_mem[8]);
        drive(1'b1, 32'h14, 1'b0, 1'b0, 4'hF, 32'h20, 32'd0);
        chk_gnt("contend fetch", 1'b1, 1'b0, 1'b0, 1'b1, 30'd5);
        push(1'b1, exp_mem[5]);

        // Starvation: four data grants, then the fetch wins once
        di = 16;
        sc = 0;
        for (int i = 0; i < 6; i++) begin
            ireq = (i <= 4);
            drive(ireq, 32'h18, 1'b1, 1'b0, 4'hF, 32'(di * 4), 32'd0);
            chk("starve_cnt", 32'(dut.starve_cnt_q), 32'(sc));
            if (i == 4) begin
                chk_gnt("starve fetch", 1'b1, 1'b0, 1'b1, 1'b1, 30'd6);
                push(1'b1, exp_mem[6]);
                sc = 0;
            end else begin
                chk_gnt("starve data", 1'b0, 1'b1, ireq, 1'b1, 30'(di));
                push(1'b0, exp_mem[di]);
                di++;
                sc = (!ireq) ? 0 : ((sc < 4) ? sc + 1 : sc);
            end
        end
        idle();
        chk("starve cleared", 32'(dut.starve_cnt_q), 32'd0);

        // Partial store then load back
        drive(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h8, 32'hAABB_CCDD);
        chk_gnt("store", 1'b0, 1'b1, 1'b0, 1'b1, 30'd2);
        chk("store mem_we", 32'(mem_we), 32'h3);
        chk("store mem_wdata", mem_wdata, 32'hAABB_CCDD);
        exp_mem[2] = {exp_mem[2][31:16], 16'hCCDD};
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h8, 32'd0);
        chk_gnt("load", 1'b0, 1'b1, 1'b0, 1'b1, 30'd2);
        push(1'b0, exp_mem[2]);
        idle();
        chk("load low half", 32'(d_rdata[15:0]), 32'h0000_CCDD);

        // Store with no byte enables is a granted no-op
        drive(1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'hC, 32'hFFFF_FFFF);
        chk_gnt("nop store", 1'b0, 1'b1, 1'b0, 1'b1, 30'd3);
        chk("nop store mem_we", 32'(mem_we), 32'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'hC, 32'd0);
        push(1'b0, exp_mem[3]);
        idle();
        idle();
        chk("d_rdata hold", d_rdata, exp_mem[3]);
        chk("if_rdata hold", if_rdata, exp_mem[6]);

        // Misaligned fetch
        drive(1'b1, 32'h6, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        chk_gnt("misaligned", 1'b1, 1'b0, 1'b0, 1'b0, 30'd0);
        chk("misaligned if_err", 32'(if_err), 32'd1);
        idle();
        chk("if_err pulse", 32'(if_err), 32'd0);

        // Reset right after a read grant drops the response
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        chk_gnt("pre-reset fetch", 1'b1, 1'b0, 1'b0, 1'b1, 30'd4);
        @(negedge clk);
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
        #1;
        chk("rst if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst if_rdata", if_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        chk("rst if_err", 32'(if_err), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk_gnt("rst", 1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
        @(negedge clk);
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #1;
        check_resp();
        chk("post-reset state", 32'(dut.state_q), 32'(IDLE));
        chk("post-reset if_rdata", if_rdata, 32'd0);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while a fetch waits.
REQ-002 Single clock; reset SHALL be synchronous, active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  sync active-high reset.
REQ-005 if_req  in  1  fetch request; held with if_addr stable until if_gnt.
REQ-006 if_addr  in  32  fetch byte address (PC).
REQ-007 if_gnt / if_rvalid / if_err  out  1 each  fetch accepted / fetch data valid / misaligned fetch.
REQ-008 if_rdata  out  32  instruction word.
REQ-009 d_req, d_we  in  1 each  data request, write (1) or read (0); held until d_gnt.
REQ-010 d_be  in  4  byte enables; d_addr, d_wdata  in  32 each.
REQ-011 d_gnt / d_rvalid  out  1 each  data accepted / load data valid; d_rdata  out  32.
REQ-012 mem_en  out  1; mem_we  out  4; mem_addr  out  30 (word index); mem_wdata  out  32; mem_rdata  in  32  (single-port sync RAM, 1-cycle read latency).
REQ-013 stall  out  1  high when any pending request is not granted this cycle.

Function
REQ-014 At most one memory access issued per cycle; grant SHALL be combinational in the request cycle.
REQ-015 Arbitration: d_req beats if_req, unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-016 starve_cnt: +1 per data grant while if_req high and not granted; cleared on fetch grant or if_req low; saturates at STARVE_MAX.
REQ-017 Granted access drives mem_en=1, mem_addr=addr[31:2]; write sets mem_we=d_be, mem_wdata=d_wdata; read sets mem_we=0.
REQ-018 Read response: rvalid for the granted port exactly one cycle after grant, rdata=mem_rdata; rdata holds last value otherwise.
REQ-019 Writes produce no d_rvalid; d_gnt completes the write.
REQ-020 d_we=1 with d_be=0 is granted but drives mem_we=0 (no-op).
REQ-021 if_addr[1:0]!=0: no memory access; if_gnt and if_err pulse same cycle; fetch counts as granted for REQ-016.
REQ-022 Back-to-back: new grant legal in the cycle a prior rvalid is returned (throughput 1 access/cycle).
REQ-023 FSM states IDLE, RESP_IF, RESP_D: IDLE->RESP_IF on fetch read grant, ->RESP_D on data read grant; RESP_x returns to IDLE or re-enters RESP_x per that cycle's grant; write grants go to IDLE.
REQ-024 stall = (if_req & ~if_gnt) | (d_req & ~d_gnt).

Reset
REQ-025 Reset SHALL force state IDLE, starve_cnt 0, if_rdata/d_rdata 0, all rvalid/gnt/err/mem_en/mem_we 0.
REQ-026 Reset while RESP_x pending SHALL drop the response; no rvalid in the cycle after reset deasserts.
REQ-027 Requests during reset are ignored; no grants while reset high.

Structure
REQ-028 Package mem_port_pkg holds state enum (IDLE, RESP_IF, RESP_D), owner enum (OWN_NONE, OWN_IF, OWN_D), STARVE_MAX default.
REQ-029 One sub-module mem_port_arb: combinational priority/starvation selection; FSM, counter and response regs in top.
REQ-030 Target 150-300 lines RTL.

Verification
REQ-031 if_req=1, if_addr=0x10, mem word4=0x00500093 -> if_gnt same cycle, mem_addr=4, next cycle if_rvalid=1, if_rdata=0x00500093.
REQ-032 if_req and d_req (read 0x20) same cycle -> d_gnt=1, if_gnt=0, stall=1; next cycle if_gnt=1, d_rvalid=1.
REQ-033 d_req held with 6 back-to-back reads, if_req held, STARVE_MAX=4 -> 4 data grants, then if_gnt on 5th cycle, starve_cnt=0.
REQ-034 Store d_addr=0x8, d_be=4'b0011, d_wdata=0xAABBCCDD -> mem_we=0011, mem_addr=2, no d_rvalid; later load returns low half 0xCCDD.
REQ-035 if_addr=0x6 -> if_gnt=1, if_err=1, mem_en=0, no if_rvalid.
REQ-036 Reset asserted cycle after read grant -> no rvalid, all outputs 0, state IDLE.
